// File: rtl/bc_stage_pf.sv
// rtl/bc_stage_pf.sv - instruction prefetch stage: credit-limited fetch, PC-tagged FIFO, redirect with stale-response discard
module bc_stage_pf #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_redirect,
    input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
    output logic                   o_imem_req,
    output logic [ADDR_WIDTH-1:0]  o_imem_addr,
    input  logic                   i_imem_gnt,
    input  logic                   i_imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
    output logic                   o_instr_valid,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0]  o_instr_pc,
    input  logic                   i_instr_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic [ADDR_WIDTH-1:0]  resp_pc;
    logic [CW-1:0]          outstanding;
    logic [CW-1:0]          discard;
    logic [CW-1:0]          count;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic                   valid_q;
    logic [INSTR_WIDTH-1:0] fifo_instr [DEPTH];
    logic [ADDR_WIDTH-1:0]  fifo_pc    [DEPTH];

    logic [CW-1:0] credit_sum;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] count_next;
    logic          grant;
    logic          push;
    logic          pop;

    // Every in-flight request owns a FIFO slot, so a kept response can always be pushed.
    assign credit_sum       = count + outstanding;
    assign o_imem_req       = i_rstn && (credit_sum < CW'(DEPTH));
    assign grant            = o_imem_req && i_imem_gnt;
    assign push             = i_imem_rvalid && (discard == '0) && !i_redirect;
    assign pop              = valid_q && i_instr_ready && !i_redirect;
    assign outstanding_next = outstanding + CW'(grant) - CW'(i_imem_rvalid);

    always_comb begin
        count_next = count;
        if (i_redirect) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(push) - CW'(pop);
        end
    end

    assign o_imem_addr   = fetch_pc;
    assign o_instr_valid = valid_q;
    assign o_instr       = fifo_instr[rd_ptr];
    assign o_instr_pc    = fifo_pc[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            valid_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else begin
            outstanding <= outstanding_next;
            count       <= count_next;
            valid_q     <= (count_next != '0);
            if (i_redirect) begin
                // Everything not yet returned after this edge, including a same-cycle grant, is stale.
                fetch_pc <= i_redirect_pc;
                resp_pc  <= i_redirect_pc;
                discard  <= outstanding_next;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                end
                if (i_imem_rvalid && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
                if (push) begin
                    fifo_instr[wr_ptr] <= i_imem_rdata;
                    fifo_pc[wr_ptr]    <= resp_pc;
                    wr_ptr             <= wr_ptr + PW'(1);
                    resp_pc            <= resp_pc + ADDR_WIDTH'(4);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bc_stage_pf.sv
// tb/tb_bc_stage_pf.sv - self-checking bench for bc_stage_pf against a request/epoch scoreboard
module tb_bc_stage_pf;

    localparam int DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        i_instr_ready;

    bc_stage_pf #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_instr_valid (o_instr_valid),
        .o_instr       (o_instr),
        .o_instr_pc    (o_instr_pc),
        .i_instr_ready (i_instr_ready)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {logic [31:0] addr; int due;} mem_t;
    typedef struct {logic [31:0] pc; bit stale;} fl_t;

    int checks = 0;
    int errors = 0;

    mem_t        mem_q[$];
    fl_t         inflight[$];
    logic [31:0] m_fifo[$];
    logic [31:0] m_fetch;
    int          cyc = 0;
    int          last_due = 0;
    int          gnt_pct = 100;
    int          lat_lo = 1;
    int          lat_hi = 1;

    logic        s_req, s_valid, e_req, e_valid, popped;
    logic [31:0] s_addr, s_pc, s_instr, e_addr, e_pc, pop_pc;
    int          s_disc, s_out, s_cnt, e_disc, e_out;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000 ^ {pc[15:0], pc[31:16]};
    endfunction

    // One clock: drive inputs at the falling edge, snapshot DUT and model, advance both across the rising edge.
    task automatic tick(input bit rdy, input bit rd, input logic [31:0] rpc);
        int due;
        fl_t fl;
        i_instr_ready = rdy;
        i_redirect    = rd;
        i_redirect_pc = rpc;
        i_imem_gnt    = ($urandom_range(99) < gnt_pct);
        i_imem_rvalid = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        i_imem_rdata  = i_imem_rvalid ? word_of(mem_q[0].addr) : 32'h0;
        #1;
        s_req = o_imem_req; s_addr = o_imem_addr; s_valid = o_instr_valid;
        s_pc = o_instr_pc; s_instr = o_instr;
        s_disc = int'(dut.discard); s_out = int'(dut.outstanding); s_cnt = int'(dut.count);
        e_req   = (m_fifo.size() + inflight.size() < DEPTH);
        e_addr  = m_fetch;
        e_valid = (m_fifo.size() > 0);
        e_pc    = e_valid ? m_fifo[0] : 32'h0;
        e_out   = inflight.size();
        e_disc  = 0;
        foreach (inflight[i]) if (inflight[i].stale) e_disc++;
        if (i_imem_rvalid) void'(mem_q.pop_front());
        if (s_req && i_imem_gnt) begin
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{addr: s_addr, due: due});
        end
        popped = 1'b0;
        if (e_valid && rdy && !rd) begin
            popped = 1'b1;
            pop_pc = m_fifo.pop_front();
        end
        if (i_imem_rvalid && inflight.size() > 0) begin
            fl = inflight.pop_front();
            if (!fl.stale && !rd) m_fifo.push_back(fl.pc);
        end
        if (e_req && i_imem_gnt) inflight.push_back('{pc: m_fetch, stale: rd});
        if (rd) begin
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            m_fifo.delete();
            m_fetch = rpc;
        end else if (e_req && i_imem_gnt) begin
            m_fetch = m_fetch + 32'd4;
        end
        @(posedge i_clk);
        cyc++;
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rstn = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0; i_instr_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        mem_q.delete(); inflight.delete(); m_fifo.delete();
        m_fetch = 32'h0; last_due = cyc;
        i_rstn = 1'b1;
    endtask

    task automatic test_reset();
        i_rstn = 1'b0; i_redirect = 1'b0; i_imem_gnt = 1'b1; i_imem_rvalid = 1'b0;
        i_instr_ready = 1'b1; i_redirect_pc = 32'h0; i_imem_rdata = 32'h0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        #1;
        checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", o_imem_req); end
        checks++; if (o_imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", o_imem_addr); end
        checks++; if (o_instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_instr_valid); end
        checks++; if (o_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", o_instr); end
        checks++; if (o_instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", o_instr_pc); end
        i_rstn = 1'b1;
        #1;
        checks++; if (o_imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", o_imem_req); end
        @(negedge i_clk);
        do_reset();
    endtask

    task automatic test_stream();
        do_reset();
        gnt_pct = 100; lat_lo = 1; lat_hi = 1;
        for (int k = 0; k < 12; k++) begin
            tick(1'b1, 1'b0, 32'h0);
            checks++; if (s_req !== 1'b1 || s_addr !== 32'(4 * k)) begin
                errors++; $display("FAIL stream_addr k=%0d got %b/%h exp 1/%h", k, s_req, s_addr, 32'(4 * k));
            end
            checks++; if (s_valid !== (k >= 2)) begin
                errors++; $display("FAIL stream_valid k=%0d got %b exp %b", k, s_valid, (k >= 2));
            end
            if (k >= 2) begin
                checks++; if (s_pc !== 32'(4 * (k - 2)) || s_instr !== word_of(32'(4 * (k - 2)))) begin
                    errors++; $display("FAIL stream_data k=%0d got %h/%h exp %h", k, s_pc, s_instr, 32'(4 * (k - 2)));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int grants;
        int n;
        logic [31:0] first_addr;
        bit seen;
        do_reset();
        gnt_pct = 100; lat_lo = 1; lat_hi = 1;
        grants = 0;
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b0, 32'h0);
            if (s_req && i_imem_gnt) grants++;
        end
        checks++; if (grants != DEPTH) begin errors++; $display("FAIL bp_grants got %0d exp %0d", grants, DEPTH); end
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL bp_req_stall got %b exp 0", s_req); end
        n = 0; seen = 1'b0; first_addr = 32'h0;
        for (int k = 0; k < 12; k++) begin
            tick(1'b1, 1'b0, 32'h0);
            if (s_req && !seen) begin seen = 1'b1; first_addr = s_addr; end
            if (s_valid && n < 4) begin
                checks++; if (s_pc !== 32'(4 * n)) begin
                    errors++; $display("FAIL bp_drain n=%0d got %h exp %h", n, s_pc, 32'(4 * n));
                end
                n++;
            end
        end
        checks++; if (n != 4) begin errors++; $display("FAIL bp_drain_count got %0d exp 4", n); end
        checks++; if (!seen || first_addr !== 32'h10) begin
            errors++; $display("FAIL bp_resume_addr got %b/%h exp 1/00000010", seen, first_addr);
        end
    endtask

    task automatic test_redirect();
        bit seen;
        do_reset();
        gnt_pct = 100; lat_lo = 3; lat_hi = 3;
        tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 32'h100);
        checks++; if (s_out != 2) begin errors++; $display("FAIL rd_outstanding got %0d exp 2", s_out); end
        tick(1'b1, 1'b0, 32'h0);
        checks++; if (s_valid !== 1'b0 || s_addr !== 32'h100) begin
            errors++; $display("FAIL rd_after got %b/%h exp 0/00000100", s_valid, s_addr);
        end
        checks++; if (s_disc != 3 || s_disc != e_disc) begin
            errors++; $display("FAIL rd_discard got %0d exp 3 model %0d", s_disc, e_disc);
        end
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(1'b1, 1'b0, 32'h0);
            if (s_valid) begin
                if (!seen) begin
                    checks++; if (s_pc !== 32'h100) begin errors++; $display("FAIL rd_first_pc got %h exp 00000100", s_pc); end
                end
                seen = 1'b1;
                checks++; if (s_pc < 32'h100) begin errors++; $display("FAIL rd_stale_pc got %h exp >=00000100", s_pc); end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rd_no_output got 0 exp 1"); end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        gnt_pct = 100; lat_lo = 1; lat_hi = 1;
        repeat (5) tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 32'h2000);
        checks++; if (!(s_req && i_imem_gnt && i_imem_rvalid)) begin
            errors++; $display("FAIL sc_setup got req%b gnt%b rv%b exp 111", s_req, i_imem_gnt, i_imem_rvalid);
        end
        tick(1'b1, 1'b0, 32'h0);
        checks++; if (s_disc != 1 || s_disc != e_disc) begin
            errors++; $display("FAIL sc_discard got %0d exp 1 model %0d", s_disc, e_disc);
        end
        checks++; if (s_valid !== 1'b0 || s_addr !== 32'h2000) begin
            errors++; $display("FAIL sc_r1 got %b/%h exp 0/00002000", s_valid, s_addr);
        end
        tick(1'b1, 1'b0, 32'h0);
        checks++; if (s_valid !== 1'b0 || s_disc != 0) begin
            errors++; $display("FAIL sc_r2 got %b/%0d exp 0/0", s_valid, s_disc);
        end
        tick(1'b1, 1'b0, 32'h0);
        checks++; if (s_valid !== 1'b1 || s_pc !== 32'h2000 || s_instr !== word_of(32'h2000)) begin
            errors++; $display("FAIL sc_r3 got %b/%h/%h exp 1/00002000", s_valid, s_pc, s_instr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        gnt_pct = 100; lat_lo = 1; lat_hi = 1;
        tick(1'b1, 1'b1, 32'hFFFF_FFFC);
        tick(1'b1, 1'b0, 32'h0);
        checks++; if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_addr0 got %b/%h exp 1/fffffffc", s_req, s_addr);
        end
        tick(1'b1, 1'b0, 32'h0);
        checks++; if (s_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr1 got %h exp 00000000", s_addr); end
        tick(1'b1, 1'b0, 32'h0);
        checks++; if (s_valid !== 1'b1 || s_pc !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_out0 got %b/%h exp 1/fffffffc", s_valid, s_pc);
        end
        tick(1'b1, 1'b0, 32'h0);
        checks++; if (s_valid !== 1'b1 || s_pc !== 32'h0) begin
            errors++; $display("FAIL wrap_out1 got %b/%h exp 1/00000000", s_valid, s_pc);
        end
    endtask

    task automatic test_random();
        int accepted;
        bit rd;
        do_reset();
        lat_lo = 1; lat_hi = 4;
        accepted = 0;
        for (int k = 0; k < 10000; k++) begin
            if (k % 500 == 0) gnt_pct = $urandom_range(100, 30);
            rd = ($urandom_range(99) < 3);
            tick($urandom_range(99) < 70, rd, $urandom & 32'hFFFF_FFFC);
            checks++; if (s_req !== e_req || (e_req && s_addr !== e_addr)) begin
                errors++; $display("FAIL rnd_req k=%0d got %b/%h exp %b/%h", k, s_req, s_addr, e_req, e_addr);
            end
            checks++; if (s_valid !== e_valid || (e_valid && (s_pc !== e_pc || s_instr !== word_of(e_pc)))) begin
                errors++; $display("FAIL rnd_out k=%0d got %b/%h/%h exp %b/%h", k, s_valid, s_pc, s_instr, e_valid, e_pc);
            end
            checks++; if (s_disc != e_disc || s_out != e_out) begin
                errors++; $display("FAIL rnd_disc k=%0d got %0d/%0d exp %0d/%0d", k, s_disc, s_out, e_disc, e_out);
            end
            checks++; if (s_cnt + s_out > DEPTH) begin
                errors++; $display("FAIL rnd_credit k=%0d got %0d exp <=%0d", k, s_cnt + s_out, DEPTH);
            end
            if (popped) accepted++;
        end
        checks++; if (accepted < 2000) begin errors++; $display("FAIL rnd_progress got %0d exp >=2000", accepted); end
    endtask

    initial begin
        i_rstn = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0; i_imem_gnt = 1'b0;
        i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0; i_instr_ready = 1'b0;
        @(negedge i_clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_same_cycle();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bc_stage_pf.md
# bc_stage_pf

Instruction prefetch stage, sitting directly upstream of the instruction-decode stage. It owns the fetch PC and issues in-order word requests to instruction memory. Returned instructions are buffered, each tagged with its PC, in a small FIFO. The FIFO is presented to decode through a valid/ready handshake. A redirect from later stages restarts fetch at a new PC and discards all stale work, including responses still in flight.

## Interface
- `ADDR_WIDTH`, 32, width of PC and memory address.
- `INSTR_WIDTH`, 32, instruction word width.
- `DEPTH`, 4, FIFO entries and maximum in-flight credit; power of two, ≥2.
- `RESET_PC`, 0, first fetch address after reset.
- `i_clk`  in  1  sole clock; all state on rising edge.
- `i_rstn`  in  1  synchronous, active-low reset.
- `i_redirect`  in  1  restart fetch at `i_redirect_pc` (single-cycle pulse or level).
- `i_redirect_pc`  in  ADDR_WIDTH  new fetch PC, word aligned.
- `o_imem_req`  out  1  request valid.
- `o_imem_addr`  out  ADDR_WIDTH  request address.
- `i_imem_gnt`  in  1  request accepted this cycle when `o_imem_req` is also 1.
- `i_imem_rvalid`  in  1  response valid; exactly one per granted request, in order, no earlier than the cycle after grant.
- `i_imem_rdata`  in  INSTR_WIDTH  response word.
- `o_instr_valid`  out  1  FIFO head valid.
- `o_instr`  out  INSTR_WIDTH  head instruction.
- `o_instr_pc`  out  ADDR_WIDTH  head PC.
- `i_instr_ready`  in  1  decode accepts head when `o_instr_valid` is also 1.

## Operation
- Registers:
  - `fetch_pc`: next request address; drives `o_imem_addr`.
  - `resp_pc`: PC of the next kept response.
  - `outstanding`: granted requests not yet returned, 0..DEPTH.
  - `discard`: stale responses still to drop, 0..DEPTH.
  - FIFO of {instr, pc}, with occupancy `count`.
- Credit: `o_imem_req = (count + outstanding < DEPTH)`, computed in a width of clog2(DEPTH)+1 bits. `o_imem_req` is 0 during reset.
- Grant (`req & gnt`): `fetch_pc += 4` (wraps modulo 2^ADDR_WIDTH); `outstanding++`.
- Response:
  - Always `outstanding--`.
  - If `discard > 0`: `discard--` and the data is dropped.
  - Otherwise {rdata, resp_pc} is pushed and `resp_pc += 4`.
- Push cannot overflow, because the credit rule guarantees space.
- Pop (`valid & ready`): the head advances. Push and pop in the same cycle leave `count` unchanged.
- A request that has not been granted may be withdrawn or have its address changed. The memory side tolerates this.
- Redirect (highest priority):
  - `fetch_pc <= i_redirect_pc`; `resp_pc <= i_redirect_pc`.
  - FIFO flushed (`count <= 0`); a same-cycle pop or push is ignored.
  - `discard <= outstanding + (req & gnt) − (rvalid ? 1 : 0)`, saturating at the existing `discard` accounting. Every response not yet returned at the redirect edge is stale, including one granted in the redirect cycle.
  - `outstanding` updates normally from that cycle's gnt/rvalid.
- During discard, new requests continue, subject to credit. Responses to them are kept only after `discard` reaches 0.

## Timing
- Reset values:
  - `o_imem_req = 0`
  - `o_imem_addr = RESET_PC`
  - `o_instr_valid = 0`
  - `o_instr = 0`
  - `o_instr_pc = 0`
  - `outstanding = 0`, `discard = 0`, `count = 0`, `resp_pc = RESET_PC`
- First cycle after reset deassertion: `o_imem_req = 1`.
- Latency: grant in cycle N, rvalid in N+1 → `o_instr_valid = 1` in N+2. There is no combinational path from rdata to `o_instr`.
- Throughput: 1 instruction/cycle with 1-cycle memory latency needs DEPTH ≥ 3. DEPTH = 2 gives one every other cycle at worst.
- `o_instr_valid`, `o_instr` and `o_instr_pc` are registered. While valid and not accepted, they hold stable.
- Redirect in cycle R:
  - `o_instr_valid = 0` at R+1.
  - `o_imem_addr = i_redirect_pc` at R+1, with req if credit allows.
- Reset asserted mid-operation discards everything at the next edge. Responses to pre-reset grants must not arrive after reset; this is a system rule.

## Test plan
- Reset, 1-cycle memory with gnt always 1, decode ready always 1 → addresses 0, 4, 8, … one per cycle. `o_instr_valid` first high 2 cycles after the first grant, then high every cycle, with `o_instr_pc` = 0, 4, 8 matching rdata.
- Decode ready held 0, DEPTH = 4 → exactly 4 grants, then `o_imem_req = 0`. The FIFO holds PCs 0–12. Releasing ready drains them in order and requests resume from address 16.
- Redirect to 0x100 while 2 responses are outstanding (3-cycle memory latency) → both responses dropped. First valid output has PC 0x100. No stale PC ever appears at the output.
- Redirect in the same cycle as a grant and an rvalid → the granted request's response is dropped; `discard` ends at the correct count (checked against a scoreboard).
- Random gnt, random ready, random memory latency of 1–4 cycles, random redirects, 10k cycles → output stream equals the reference PC sequence with no loss or duplication. Invariant `count + outstanding ≤ DEPTH` always holds.
- `fetch_pc` = 0xFFFF_FFFC → next request address is 0x0000_0000.
